// File: rtl/dsp_sys_arr_pkg.sv
// Types and constants shared by the systolic-array operand feeders and PEs.
package dsp_sys_arr_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOADED    = 3'd1,
    SKEW_WAIT = 3'd2,
    STREAM    = 3'd3,
    DONE      = 3'd4
  } feeder_state_t;

  localparam int FEEDER_MAX_SKEW = 255;

endpackage

// File: rtl/feeder_buf.sv
// Operand vector storage: synchronous write port, combinational read port.
module feeder_buf
  import dsp_sys_arr_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  word_t         wr_dat,
  input  logic [AW-1:0] rd_addr,
  output word_t         rd_dat
);

  word_t mem_q [DEPTH];

  // Contents are never reset; only entries below the loaded length are read.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_dat;
    end
  end

  assign rd_dat = mem_q[rd_addr];

endmodule

// File: rtl/sys_arr_edge_feeder.sv
// Buffers one operand vector and streams it, after a programmable start skew,
// into a systolic-array edge PE over a valid/ready interface.
module sys_arr_edge_feeder
  import dsp_sys_arr_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int SKEW  = 0,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             ld_valid,
  input  word_t            ld_dat,
  input  logic             ld_last,
  output logic             ld_ready,
  input  logic             start,
  output logic             out_valid,
  input  logic             out_ready,
  output word_t            out_dat,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] vec_len
);

  localparam int AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SKEW_LIM = (SKEW > FEEDER_MAX_SKEW) ? FEEDER_MAX_SKEW : SKEW;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
  localparam logic [7:0]       SKEW_C  = 8'(SKEW_LIM);

  feeder_state_t    state_q, state_d;
  logic [CNT_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] vec_len_q, vec_len_d;
  logic [7:0]       skew_cnt_q, skew_cnt_d;
  logic             ld_ready_q, ld_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             wr_en_s;
  logic             hs_s;
  word_t            rd_dat_s;

  feeder_buf #(.DEPTH(DEPTH), .AW(AW)) u_buf (
    .clk     (clk),
    .wr_en   (wr_en_s),
    .wr_addr (wr_ptr_q[AW-1:0]),
    .wr_dat  (ld_dat),
    .rd_addr (rd_ptr_q[AW-1:0]),
    .rd_dat  (rd_dat_s)
  );

  // Next-state, pointer and registered-output computation.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    vec_len_d  = vec_len_q;
    skew_cnt_d = skew_cnt_q;
    wr_en_s    = 1'b0;
    hs_s       = out_valid_q && out_ready;
    case (state_q)
      IDLE: begin
        if (ld_valid && ld_ready_q) begin
          wr_en_s  = 1'b1;
          wr_ptr_d = wr_ptr_q + ONE_C;
          // A beat that fills the buffer ends the load even without ld_last.
          if (ld_last || (wr_ptr_d == DEPTH_C)) begin
            state_d   = LOADED;
            vec_len_d = wr_ptr_d;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      LOADED: begin
        if (start) begin
          if (SKEW_C == 8'd0) begin
            state_d = STREAM;
          end else begin
            state_d    = SKEW_WAIT;
            skew_cnt_d = SKEW_C;
          end
        end else begin
          state_d = LOADED;
        end
      end
      SKEW_WAIT: begin
        skew_cnt_d = skew_cnt_q - 8'd1;
        if (skew_cnt_q <= 8'd1) begin
          state_d = STREAM;
        end else begin
          state_d = SKEW_WAIT;
        end
      end
      STREAM: begin
        if (hs_s) begin
          rd_ptr_d = rd_ptr_q + ONE_C;
          if (rd_ptr_d == vec_len_q) begin
            state_d = DONE;
          end else begin
            state_d = STREAM;
          end
        end else begin
          state_d = STREAM;
        end
      end
      DONE: begin
        wr_ptr_d  = {CNT_W{1'b0}};
        rd_ptr_d  = {CNT_W{1'b0}};
        vec_len_d = {CNT_W{1'b0}};
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    ld_ready_d  = (state_d == IDLE) && (wr_ptr_d < DEPTH_C);
    out_valid_d = (state_d == STREAM);
    busy_d      = (state_d == SKEW_WAIT) || (state_d == STREAM);
    done_d      = (state_d == DONE);
  end

  // State and output registers; reset returns every output to zero at once.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= {CNT_W{1'b0}};
      rd_ptr_q    <= {CNT_W{1'b0}};
      vec_len_q   <= {CNT_W{1'b0}};
      skew_cnt_q  <= 8'd0;
      ld_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      vec_len_q   <= vec_len_d;
      skew_cnt_q  <= skew_cnt_d;
      ld_ready_q  <= ld_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign ld_ready  = ld_ready_q;
  assign out_valid = out_valid_q;
  assign out_dat   = out_valid_q ? rd_dat_s : 32'h0000_0000;
  assign busy      = busy_q;
  assign done      = done_q;
  assign vec_len   = vec_len_q;

endmodule

// File: tb/tb_sys_arr_edge_feeder.sv
// Scoreboard bench: two feeders (SKEW=0 and SKEW=3) share one stimulus stream.
module tb_sys_arr_edge_feeder;
  import dsp_sys_arr_pkg::*;

  localparam int DEPTH = 16;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic nrst = 1'b0;
  logic ld_valid = 1'b0;
  word_t ld_dat = 32'h0;
  logic ld_last = 1'b0;
  logic start = 1'b0;
  logic out_ready = 1'b1;

  logic             ld_ready_s  [2];
  logic             out_valid_s [2];
  word_t            out_dat_s   [2];
  logic             busy_s      [2];
  logic             done_s      [2];
  logic [CNT_W-1:0] vec_len_s   [2];

  sys_arr_edge_feeder #(.DEPTH(DEPTH), .SKEW(0)) u_dut0 (
    .clk(clk), .nrst(nrst), .ld_valid(ld_valid), .ld_dat(ld_dat), .ld_last(ld_last),
    .ld_ready(ld_ready_s[0]), .start(start), .out_valid(out_valid_s[0]),
    .out_ready(out_ready), .out_dat(out_dat_s[0]), .busy(busy_s[0]),
    .done(done_s[0]), .vec_len(vec_len_s[0])
  );

  sys_arr_edge_feeder #(.DEPTH(DEPTH), .SKEW(3)) u_dut1 (
    .clk(clk), .nrst(nrst), .ld_valid(ld_valid), .ld_dat(ld_dat), .ld_last(ld_last),
    .ld_ready(ld_ready_s[1]), .start(start), .out_valid(out_valid_s[1]),
    .out_ready(out_ready), .out_dat(out_dat_s[1]), .busy(busy_s[1]),
    .done(done_s[1]), .vec_len(vec_len_s[1])
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;
  word_t exp0[$];
  word_t exp1[$];
  word_t loaded[$];
  word_t src[20];
  int hs[2], done_n[2], first_v[2], last_hs[2], done_cyc[2], valid_n[2];
  logic stall_p[2];
  word_t dat_p[2];
  bit pat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Output monitor: scoreboard pops, stall stability, handshake/done timing.
  always @(negedge clk) begin
    word_t e;
    logic ok;
    for (int i = 0; i < 2; i++) begin
      if (!nrst) begin
        stall_p[i] = 1'b0;
      end else begin
        if (out_valid_s[i]) begin
          valid_n[i]++;
          if (first_v[i] < 0) first_v[i] = cyc;
        end
        if (stall_p[i]) begin
          chk($sformatf("d%0d_hold_valid", i), 32'(out_valid_s[i]), 32'd1);
          chk($sformatf("d%0d_hold_dat", i), out_dat_s[i], dat_p[i]);
        end
        if (out_valid_s[i] && out_ready) begin
          hs[i]++;
          last_hs[i] = cyc;
          e = 32'h0;
          if (i == 0) begin
            ok = (exp0.size() != 0);
            if (ok) e = exp0.pop_front();
          end else begin
            ok = (exp1.size() != 0);
            if (ok) e = exp1.pop_front();
          end
          chk($sformatf("d%0d_sb_nonempty", i), 32'(ok), 32'd1);
          if (ok) chk($sformatf("d%0d_dat", i), out_dat_s[i], e);
        end
        if (done_s[i]) begin
          done_n[i]++;
          done_cyc[i] = cyc;
        end
        stall_p[i] = out_valid_s[i] && !out_ready;
        dat_p[i]   = out_dat_s[i];
      end
    end
  end

  task automatic clear_mon();
    for (int i = 0; i < 2; i++) begin
      hs[i] = 0; done_n[i] = 0; first_v[i] = -1;
      last_hs[i] = -1; done_cyc[i] = -1; valid_n[i] = 0;
    end
  endtask

  task automatic load(input int n, input int last_idx);
    int target;
    logic acc;
    target = (last_idx + 1 < DEPTH) ? last_idx + 1 : DEPTH;
    loaded.delete();
    for (int i = 0; i < n; i++) begin
      ld_valid = 1'b1;
      ld_dat   = src[i];
      ld_last  = (i == last_idx);
      acc = 1'b0;
      for (int w = 0; w < 4 && !acc; w++) begin
        @(negedge clk);
        acc = ld_ready_s[0];
        @(posedge clk);
        #1;
      end
      chk($sformatf("ld_accept_%0d", i), 32'(acc), 32'(i < target));
      if (i < target) loaded.push_back(src[i]);
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    @(negedge clk);
    chk("vec_len0", 32'(vec_len_s[0]), 32'(target));
    chk("vec_len1", 32'(vec_len_s[1]), 32'(target));
    @(posedge clk);
    #1;
  endtask

  task automatic run(input bit bp, input bit inj, input bit abort);
    int t;
    int k;
    clear_mon();
    k = loaded.size();
    exp0 = loaded;
    exp1 = loaded;
    start = 1'b1;
    t = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int j = 0; j < 80; j++) begin
      if (abort && hs[0] >= 2) break;
      if (done_n[0] > 0 && done_n[1] > 0) break;
      out_ready = (bp && j < 7) ? pat[j] : 1'b1;
      start = (inj && j == 2);
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    out_ready = 1'b1;
    if (!abort) begin
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("d%0d_handshakes", i), 32'(hs[i]), 32'(k));
        chk($sformatf("d%0d_done_count", i), 32'(done_n[i]), 32'd1);
        chk($sformatf("d%0d_done_after_last", i), 32'(done_cyc[i] - last_hs[i]), 32'd1);
        chk($sformatf("d%0d_sb_empty", i), 32'(i == 0 ? exp0.size() : exp1.size()), 32'd0);
        if (!bp) begin
          chk($sformatf("d%0d_first_valid_lat", i), 32'(first_v[i] - t), 32'(i == 0 ? 1 : 4));
          chk($sformatf("d%0d_done_lat", i), 32'(done_cyc[i] - t), 32'(k + (i == 0 ? 1 : 4)));
        end
      end
    end
  endtask

  task automatic chk_zero(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s_d%0d_out_valid", tag, i), 32'(out_valid_s[i]), 32'd0);
      chk($sformatf("%s_d%0d_busy", tag, i), 32'(busy_s[i]), 32'd0);
      chk($sformatf("%s_d%0d_done", tag, i), 32'(done_s[i]), 32'd0);
      chk($sformatf("%s_d%0d_vec_len", tag, i), 32'(vec_len_s[i]), 32'd0);
      chk($sformatf("%s_d%0d_ld_ready", tag, i), 32'(ld_ready_s[i]), 32'd0);
    end
  endtask

  initial begin
    clear_mon();
    repeat (3) @(negedge clk);
    chk_zero("reset");
    chk("reset_out_dat", out_dat_s[0], 32'h0);
    @(posedge clk);
    #1;
    nrst = 1'b1;

    // Start with nothing loaded must be ignored.
    repeat (2) @(posedge clk);
    #1;
    clear_mon();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("idle_start_valid0", 32'(valid_n[0]), 32'd0);
    chk("idle_start_valid1", 32'(valid_n[1]), 32'd0);
    chk("idle_ld_ready", 32'(ld_ready_s[0]), 32'd1);

    src[0] = 32'h3F80_0000; src[1] = 32'h4000_0000;
    src[2] = 32'h4040_0000; src[3] = 32'h4080_0000;
    load(4, 3);
    run(1'b0, 1'b0, 1'b0);

    // Loads offered while LOADED must not be taken.
    load(4, 3);
    for (int c = 0; c < 3; c++) begin
      ld_valid = 1'b1;
      ld_dat   = 32'hDEAD_BEEF;
      ld_last  = 1'b1;
      @(negedge clk);
      chk("loaded_ld_ready", 32'(ld_ready_s[0]), 32'd0);
      @(posedge clk);
      #1;
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    run(1'b1, 1'b0, 1'b0);

    load(4, 3);
    run(1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 20; i++) src[i] = 32'h4100_0000 + 32'(i);
    load(20, 19);
    run(1'b0, 1'b0, 1'b0);

    src[0] = 32'h3F80_0000; src[1] = 32'h4000_0000;
    src[2] = 32'h4040_0000; src[3] = 32'h4080_0000;
    load(4, 3);
    run(1'b0, 1'b0, 1'b1);
    chk("abort_hs", 32'(hs[0]), 32'd2);
    nrst = 1'b0;
    #1;
    chk_zero("midrst");
    exp0.delete();
    exp1.delete();
    repeat (2) @(posedge clk);
    #1;
    nrst = 1'b1;

    src[0] = 32'h4110_0000; src[1] = 32'h4120_0000;
    load(2, 1);
    run(1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
